// File: rtl/aes_round_sequencer.sv
// Control sequencer for the iterative AES round datapath: accepts one block at a time,
// steps the round index (10/12/14 rounds), holds results under backpressure and counts blocks per job.
module aes_round_sequencer #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned RND_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable_i,
  input  logic             start_i,
  input  logic [1:0]       key_len_i,
  input  logic [CNT_W-1:0] nb_blocks_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             load_o,
  output logic             round_en_o,
  output logic [RND_W-1:0] round_o,
  output logic             last_round_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] blk_cnt_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_ROUND  = 2'd2,
    S_OUTPUT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [RND_W-1:0] nr_q, nr_d;
  logic [CNT_W-1:0] nb_q, nb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             in_ready_c, load_c, round_en_c, last_round_c, out_valid_c;
  logic [RND_W-1:0] nr_sel;
  logic [CNT_W-1:0] cnt_inc;

  // Round count by key length; the reserved encoding behaves as AES-128.
  always_comb begin
    nr_sel = RND_W'(10);
    case (key_len_i)
      2'd1:    nr_sel = RND_W'(12);
      2'd2:    nr_sel = RND_W'(14);
      default: nr_sel = RND_W'(10);
    endcase
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and decoded datapath controls; enable_i low leaves every register as is.
  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    nr_d         = nr_q;
    nb_d         = nb_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    in_ready_c   = 1'b0;
    load_c       = 1'b0;
    round_en_c   = 1'b0;
    last_round_c = 1'b0;
    out_valid_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && enable_i) begin
          cnt_d = '0;
          rnd_d = '0;
          nr_d  = nr_sel;
          nb_d  = nb_blocks_i;
          if (nb_blocks_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        in_ready_c = enable_i;
        if (enable_i && in_valid_i) begin
          load_c  = 1'b1;
          rnd_d   = RND_W'(1);
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        round_en_c   = enable_i;
        last_round_c = (rnd_q == nr_q);
        if (enable_i) begin
          if (rnd_q == nr_q) begin
            state_d = S_OUTPUT;
          end else begin
            rnd_d = rnd_q + RND_W'(1);
          end
        end
      end
      S_OUTPUT: begin
        out_valid_c = 1'b1;
        if (enable_i && out_ready_i) begin
          cnt_d = cnt_inc;
          rnd_d = '0;
          if (cnt_inc == nb_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      nr_q    <= '0;
      nb_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (clear) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      nr_q    <= '0;
      nb_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      nr_q    <= nr_d;
      nb_q    <= nb_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign in_ready_o   = in_ready_c;
  assign load_o       = load_c;
  assign round_en_o   = round_en_c;
  assign last_round_o = last_round_c;
  assign out_valid_o  = out_valid_c;
  assign round_o      = rnd_q;
  assign busy_o       = (state_q != S_IDLE);
  assign blk_cnt_o    = cnt_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: hand-timed block jobs with stalls, enable gaps,
// clear/reset aborts and ignored starts.
module tb_aes_round_sequencer;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        enable_i;
  logic        start_i;
  logic [1:0]  key_len_i;
  logic [15:0] nb_blocks_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        load_o;
  logic        round_en_o;
  logic [3:0]  round_o;
  logic        last_round_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        busy_o;
  logic [15:0] blk_cnt_o;
  logic        done_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  aes_round_sequencer #(.CNT_W(16), .RND_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .enable_i     (enable_i),
    .start_i      (start_i),
    .key_len_i    (key_len_i),
    .nb_blocks_i  (nb_blocks_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .load_o       (load_o),
    .round_en_o   (round_en_o),
    .round_o      (round_o),
    .last_round_o (last_round_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .busy_o       (busy_o),
    .blk_cnt_o    (blk_cnt_o),
    .done_o       (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {busy, done, blk_cnt}
  function automatic logic [31:0] st_vec();
    return {14'd0, busy_o, done_o, blk_cnt_o};
  endfunction

  // {in_ready, load, round_en, last_round, out_valid, round}
  function automatic logic [31:0] ctl_vec();
    return {23'd0, in_ready_o, load_o, round_en_o, last_round_o, out_valid_o, round_o};
  endfunction

  function automatic logic [31:0] ctl_exp(input bit rdy, input bit ld, input bit ren,
                                          input bit last, input bit ov, input int rnd);
    return {23'd0, rdy, ld, ren, last, ov, 4'(rnd)};
  endfunction

  task automatic start_job(input logic [1:0] kl, input logic [15:0] nb);
    start_i     = 1'b1;
    key_len_i   = kl;
    nb_blocks_i = nb;
    step();
    start_i     = 1'b0;
    key_len_i   = 2'd0;
    nb_blocks_i = 16'hFFFF;
  endtask

  // Drives one block from LOAD through OUTPUT; returns just after the output handshake
  // edge, or right after a clear edge, or while still stalled in OUTPUT when no_ack is set.
  task automatic run_block(input int nr, input int stall, input int gap_at, input int start_at,
                           input int clear_at, input bit no_ack, input int cnt_before);
    in_valid_i = 1'b1;
    @(negedge clk);
    check("load_ctl", ctl_vec(), ctl_exp(1, 1, 0, 0, 0, 0));
    check("load_st", st_vec(), {14'd0, 1'b1, 1'b0, 16'(cnt_before)});
    step();
    in_valid_i = 1'b0;
    for (int r = 1; r <= nr; r++) begin
      if (r == gap_at) begin
        enable_i = 1'b0;
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          check("gap_ctl", ctl_vec(), ctl_exp(0, 0, 0, r == nr, 0, r));
          step();
        end
        enable_i = 1'b1;
      end
      if (r == start_at) begin
        start_i     = 1'b1;
        key_len_i   = 2'd0;
        nb_blocks_i = 16'd1;
      end
      if (r == clear_at) clear = 1'b1;
      @(negedge clk);
      check("round_ctl", ctl_vec(), ctl_exp(0, 0, 1, r == nr, 0, r));
      step();
      start_i = 1'b0;
      if (r == clear_at) begin
        clear = 1'b0;
        return;
      end
    end
    out_ready_i = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_ctl", ctl_vec(), ctl_exp(0, 0, 0, 0, 1, nr));
      check("stall_cnt", st_vec(), {14'd0, 1'b1, 1'b0, 16'(cnt_before)});
      step();
    end
    if (no_ack) return;
    out_ready_i = 1'b1;
    @(negedge clk);
    check("out_ctl", ctl_vec(), ctl_exp(0, 0, 0, 0, 1, nr));
    step();
    out_ready_i = 1'b0;
  endtask

  task automatic check_done(input string tag, input int cnt);
    @(negedge clk);
    check(tag, st_vec(), {14'd0, 1'b0, 1'b1, 16'(cnt)});
    step();
    @(negedge clk);
    check({tag, "_pulse"}, st_vec(), {14'd0, 1'b0, 1'b0, 16'(cnt)});
  endtask

  initial begin
    reset_n     = 1'b0;
    clear       = 1'b0;
    enable_i    = 1'b1;
    start_i     = 1'b0;
    key_len_i   = 2'd0;
    nb_blocks_i = 16'd0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_ctl", ctl_vec(), 32'd0);
    check("rst_st", st_vec(), 32'd0);
    reset_n = 1'b1;
    step();

    // AES-128 single block
    start_job(2'd0, 16'd1);
    run_block(10, 0, 0, 0, 0, 1'b0, 0);
    check_done("t1_done", 1);
    step();

    // AES-256, three blocks, second stalled 5 cycles
    start_job(2'd2, 16'd3);
    run_block(14, 0, 0, 0, 0, 1'b0, 0);
    run_block(14, 5, 0, 0, 0, 1'b0, 1);
    run_block(14, 0, 0, 0, 0, 1'b0, 2);
    check_done("t2_done", 3);
    step();

    // AES-192 with a 3-cycle enable gap at round 4
    start_job(2'd1, 16'd1);
    run_block(12, 0, 4, 0, 0, 1'b0, 0);
    check_done("t3_done", 1);
    step();

    // Zero-block job
    start_job(2'd0, 16'd0);
    @(negedge clk);
    check("t4_done", {31'd0, done_o}, 32'd1);
    check("t4_idle", {30'd0, busy_o, in_ready_o}, 32'd0);
    step();
    @(negedge clk);
    check("t4_pulse", {29'd0, done_o, busy_o, in_ready_o}, 32'd0);
    step();

    // Reserved key length runs 10 rounds
    start_job(2'd3, 16'd1);
    run_block(10, 0, 0, 0, 0, 1'b0, 0);
    check_done("t5_done", 1);
    step();

    // Clear during round 6 aborts the job
    start_job(2'd0, 16'd2);
    run_block(10, 0, 0, 0, 6, 1'b0, 0);
    @(negedge clk);
    check("t6_ctl", ctl_vec(), 32'd0);
    check("t6_st", st_vec(), 32'd0);
    step();
    @(negedge clk);
    check("t6_nodone", st_vec(), 32'd0);
    step();

    // Reset while stalled in OUTPUT of the second block
    start_job(2'd0, 16'd2);
    run_block(10, 0, 0, 0, 0, 1'b0, 0);
    run_block(10, 2, 0, 0, 0, 1'b1, 1);
    reset_n = 1'b0;
    #1;
    check("t7_async_ctl", ctl_vec(), 32'd0);
    check("t7_async_st", st_vec(), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    @(negedge clk);
    check("t7_nodone", st_vec(), 32'd0);
    step();

    // Start pulse during ROUND is ignored
    start_job(2'd2, 16'd2);
    run_block(14, 0, 0, 5, 0, 1'b0, 0);
    run_block(14, 0, 0, 0, 0, 1'b0, 1);
    check_done("t8_done", 2);
    step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
